// File: rtl/timer_count_unit.sv
// rtl/timer_count_unit.sv - BCD mm:ss counter with prescaler, preset load and end saturation
module timer_count_unit #(
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_enable,
    input  logic        up,
    input  logic [1:0]  mode,
    input  logic        load,
    input  logic [15:0] preset,
    output logic [15:0] value,
    output logic        at_zero,
    output logic        at_max,
    output logic        step
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [15:0]   r_value;
    logic          r_step;

    logic          w_tick;
    logic          w_can_step;
    logic [15:0]   w_inc;
    logic [15:0]   w_dec;
    logic [15:0]   w_clamped;
    logic [15:0]   w_load_value;

    assign value   = r_value;
    assign step    = r_step;
    assign at_zero = (r_value == 16'h0000);
    assign at_max  = (r_value == 16'h9959);

    assign w_tick     = count_enable && (r_presc == PRESC_LAST);
    assign w_can_step = up ? !at_max : !at_zero;

    // Per-digit clamp keeps every loaded value a legal mm:ss BCD time.
    always_comb begin
        w_clamped[15:12] = (preset[15:12] > 4'd9) ? 4'd9 : preset[15:12];
        w_clamped[11:8]  = (preset[11:8]  > 4'd9) ? 4'd9 : preset[11:8];
        w_clamped[7:4]   = (preset[7:4]   > 4'd5) ? 4'd5 : preset[7:4];
        w_clamped[3:0]   = (preset[3:0]   > 4'd9) ? 4'd9 : preset[3:0];
    end

    always_comb begin
        w_load_value = w_clamped;
        case (mode)
            2'b00:   w_load_value = 16'h0000;
            2'b01:   w_load_value = 16'h9959;
            default: w_load_value = w_clamped;
        endcase
    end

    always_comb begin
        w_inc = r_value;
        if (r_value[3:0] != 4'd9) begin
            w_inc[3:0] = r_value[3:0] + 4'd1;
        end else begin
            w_inc[3:0] = 4'd0;
            if (r_value[7:4] != 4'd5) begin
                w_inc[7:4] = r_value[7:4] + 4'd1;
            end else begin
                w_inc[7:4] = 4'd0;
                if (r_value[11:8] != 4'd9) begin
                    w_inc[11:8] = r_value[11:8] + 4'd1;
                end else begin
                    w_inc[11:8]  = 4'd0;
                    w_inc[15:12] = r_value[15:12] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_dec = r_value;
        if (r_value[3:0] != 4'd0) begin
            w_dec[3:0] = r_value[3:0] - 4'd1;
        end else begin
            w_dec[3:0] = 4'd9;
            if (r_value[7:4] != 4'd0) begin
                w_dec[7:4] = r_value[7:4] - 4'd1;
            end else begin
                w_dec[7:4] = 4'd5;
                if (r_value[11:8] != 4'd0) begin
                    w_dec[11:8] = r_value[11:8] - 4'd1;
                end else begin
                    w_dec[11:8]  = 4'd9;
                    w_dec[15:12] = r_value[15:12] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_value <= 16'h0000;
            r_presc <= '0;
            r_step  <= 1'b0;
        end else if (load) begin
            r_value <= w_load_value;
            r_presc <= '0;
            r_step  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (w_tick) begin
                r_presc <= '0;
                if (w_can_step) begin
                    r_value <= up ? w_inc : w_dec;
                    r_step  <= 1'b1;
                end
            end else if (count_enable) begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_timer_count_unit.sv
// tb/tb_timer_count_unit.sv - randomized and directed check of timer_count_unit against a seconds-based model
module tb_timer_count_unit;

    localparam int TICK_DIV = 4;
    localparam int MAX_SECS = 99 * 60 + 59;

    logic        clk = 1'b0;
    logic        reset;
    logic        count_enable;
    logic        up;
    logic [1:0]  mode;
    logic        load;
    logic [15:0] preset;
    logic [15:0] value;
    logic        at_zero;
    logic        at_max;
    logic        step;

    int errors = 0;
    int checks = 0;

    int m_secs  = 0;
    int m_presc = 0;
    bit m_step  = 1'b0;
    bit m_valid = 1'b0;

    timer_count_unit #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset(reset), .count_enable(count_enable), .up(up),
        .mode(mode), .load(load), .preset(preset), .value(value),
        .at_zero(at_zero), .at_max(at_max), .step(step)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] secs_to_bcd(input int secs);
        int mins, s;
        mins = secs / 60;
        s    = secs % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int preset_to_secs(input logic [15:0] p);
        int mt, mo, st, so;
        mt = (p[15:12] > 9) ? 9 : int'(p[15:12]);
        mo = (p[11:8]  > 9) ? 9 : int'(p[11:8]);
        st = (p[7:4]   > 5) ? 5 : int'(p[7:4]);
        so = (p[3:0]   > 9) ? 9 : int'(p[3:0]);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    // Model: time kept as plain seconds, one tick every TICK_DIV enabled cycles.
    always @(posedge clk) begin
        if (!reset) begin
            m_secs = 0; m_presc = 0; m_step = 0; m_valid = 1;
        end else if (load) begin
            m_secs  = (mode == 2'd0) ? 0 : (mode == 2'd1) ? MAX_SECS : preset_to_secs(preset);
            m_presc = 0;
            m_step  = 0;
        end else begin
            m_step = 0;
            if (count_enable) begin
                m_presc = m_presc + 1;
                if (m_presc == TICK_DIV) begin
                    m_presc = 0;
                    if (up && m_secs < MAX_SECS) begin
                        m_secs = m_secs + 1; m_step = 1;
                    end else if (!up && m_secs > 0) begin
                        m_secs = m_secs - 1; m_step = 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_value", value, secs_to_bcd(m_secs));
            check("model_at_zero", 16'(at_zero), 16'(m_secs == 0));
            check("model_at_max", 16'(at_max), 16'(m_secs == MAX_SECS));
            check("model_step", 16'(step), 16'(m_step));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int steps);
        steps = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (step) steps++;
        end
    endtask

    task automatic do_load(input logic [1:0] md, input logic [15:0] p);
        mode = md; preset = p; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    int steps;

    initial begin
        reset = 1'b0; count_enable = 1'(($urandom)); up = 1'($urandom);
        mode = 2'($urandom); load = 1'($urandom); preset = 16'($urandom);

        check("pin_bcd_max", secs_to_bcd(MAX_SECS), 16'h9959);
        check("pin_clamp", secs_to_bcd(preset_to_secs(16'hFA7C)), 16'h9959);
        check("pin_bcd_59", secs_to_bcd(59), 16'h0059);

        cyc();
        check("reset_value", value, 16'h0000);
        check("reset_at_zero", 16'(at_zero), 16'h1);
        check("reset_at_max", 16'(at_max), 16'h0);
        check("reset_step", 16'(step), 16'h0);
        reset = 1'b1; load = 1'b0; count_enable = 1'b0;

        // Increment with cascaded carry 00:59 -> 01:00
        do_load(2'b10, 16'h0059);
        check("load_0059", value, 16'h0059);
        count_enable = 1'b1; up = 1'b1;
        run(3, steps);
        check("inc_no_early_step", 16'(steps), 16'h0);
        cyc();
        check("inc_carry", value, 16'h0100);
        check("inc_step_high", 16'(step), 16'h1);
        cyc();
        check("inc_step_one_cycle", 16'(step), 16'h0);
        run(3, steps);
        check("inc_second", value, 16'h0101);

        // Top end: decrement from max, then saturate going up
        count_enable = 1'b0;
        do_load(2'b01, 16'h1234);
        check("load_max", value, 16'h9959);
        check("load_max_flag", 16'(at_max), 16'h1);
        count_enable = 1'b1; up = 1'b0;
        run(4, steps);
        check("dec_from_max", value, 16'h9958);
        check("dec_from_max_flag", 16'(at_max), 16'h0);
        do_load(2'b01, 16'h0000);
        up = 1'b1;
        run(12, steps);
        check("sat_max_value", value, 16'h9959);
        check("sat_max_no_step", 16'(steps), 16'h0);

        // Bottom end: borrow chain then saturate at zero
        do_load(2'b11, 16'h0100);
        up = 1'b0;
        run(4, steps);
        check("dec_borrow", value, 16'h0059);
        run(59 * 4, steps);
        check("dec_to_zero", value, 16'h0000);
        check("dec_zero_flag", 16'(at_zero), 16'h1);
        run(8, steps);
        check("sat_zero_value", value, 16'h0000);
        check("sat_zero_no_step", 16'(steps), 16'h0);

        // Pause preserves partial second
        count_enable = 1'b0;
        do_load(2'b10, 16'h0030);
        up = 1'b1; count_enable = 1'b1;
        run(2, steps);
        count_enable = 1'b0;
        run(10, steps);
        check("pause_hold", value, 16'h0030);
        count_enable = 1'b1;
        cyc();
        check("resume_first_no_step", 16'(step), 16'h0);
        cyc();
        check("resume_second_step", 16'(step), 16'h1);
        check("resume_value", value, 16'h0031);

        // Load coincident with a tick wins and clears the prescaler
        run(3, steps);
        do_load(2'b00, 16'h0000);
        check("load_tick_value", value, 16'h0000);
        check("load_tick_step", 16'(step), 16'h0);
        run(3, steps);
        check("load_tick_presc_cleared", value, 16'h0000);
        cyc();
        check("load_tick_next_step", value, 16'h0001);

        // Clamped preset and mid-count reset
        count_enable = 1'b0;
        do_load(2'b10, 16'hFA7C);
        check("clamp_load", value, 16'h9959);
        count_enable = 1'b1; up = 1'b0;
        run(2, steps);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("midreset_value", value, 16'h0000);
        check("midreset_zero", 16'(at_zero), 16'h1);
        up = 1'b1;
        run(3, steps);
        check("midreset_presc_restart", value, 16'h0000);
        cyc();
        check("midreset_first_step", value, 16'h0001);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 149) != 0);
            load         = ($urandom_range(0, 39) == 0);
            mode         = 2'($urandom);
            preset       = 16'($urandom);
            count_enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            cyc();
        end
        reset = 1'b1; load = 1'b0; count_enable = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
